// File: rtl/pipeline_control_if.sv
// Handshake bundle between the pipeline stages and pipeline_control.
// master: pipeline side (drives hazard/redirect inputs, receives stall/flush/redirect).
// slave:  pipeline_control itself.
`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 3
`endif

interface pipeline_control_if #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned SEL_PC_WIDTH = `SEL_PC_WIDTH,
    parameter int unsigned NSTAGE       = 4
);
    logic                    mem_req_i;
    logic                    memory_done_i;
    logic [SEL_PC_WIDTH-1:0] pc_sel_i;
    logic                    br_taken_i;
    logic [XLEN-1:0]         next_pc_i;
    logic [31:0]             ir_i;
    logic                    ex_load_i;
    logic [4:0]              ex_rd_i;
    logic [NSTAGE-1:0]       stall_o;
    logic [NSTAGE-1:0]       flush_o;
    logic                    fetch_stall_o;
    logic [SEL_PC_WIDTH-1:0] pc_sel_o;
    logic                    br_taken_o;
    logic [XLEN-1:0]         next_pc_o;
    logic                    timeout_o;

    modport master (
        output mem_req_i, memory_done_i, pc_sel_i, br_taken_i, next_pc_i, ir_i,
               ex_load_i, ex_rd_i,
        input  stall_o, flush_o, fetch_stall_o, pc_sel_o, br_taken_o, next_pc_o, timeout_o
    );

    modport slave (
        input  mem_req_i, memory_done_i, pc_sel_i, br_taken_i, next_pc_i, ir_i,
               ex_load_i, ex_rd_i,
        output stall_o, flush_o, fetch_stall_o, pc_sel_o, br_taken_o, next_pc_o, timeout_o
    );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline control unit: arbitrates memory-wait stalls, load-use hazards and
// branch/jump redirects; drives per-stage stall/flush and a registered PC redirect.
// Optional feature: define CONTROL_WATCHDOG_EN to enable the memory-wait watchdog
// (timeout_o pulse, forced return to RUN, one-cycle flush of all stages).
`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 3
`endif

module pipeline_control #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     SEL_PC_WIDTH = `SEL_PC_WIDTH,
    parameter int unsigned     NSTAGE       = 4,
    parameter int unsigned     FLUSH_STAGES = 2,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned     WDT_CYCLES   = 255
) (
    input logic               clk,
    input logic               rst,
    pipeline_control_if.slave ctrl_io
);

    localparam int unsigned FcW = $clog2(FLUSH_STAGES + 1);
    localparam logic [NSTAGE-1:0] FlushMask   = {NSTAGE{1'b1}} >> (NSTAGE - FLUSH_STAGES);
    localparam logic [NSTAGE-1:0] LuStallMask = NSTAGE'(3);
    // Bubble into execute; truncates to zero when there is no execute stage.
    localparam logic [NSTAGE-1:0] LuFlushMask = NSTAGE'(4);

    typedef enum logic [1:0] {StRun, StMemWait, StRedirect} state_e;

    state_e                  state_q;
    logic                    pend_q;
    logic [XLEN-1:0]         tgt_q;
    logic [SEL_PC_WIDTH-1:0] sel_q;
    logic                    br_taken_q;
    logic [XLEN-1:0]         next_pc_q;
    logic [SEL_PC_WIDTH-1:0] pc_sel_q;
    logic [FcW-1:0]          fcnt_q;

    logic                    mem_stall;
    logic                    load_use;
    logic                    wdt_flush;
    logic                    timeout;
    logic [NSTAGE-1:0]       stall;
    logic [NSTAGE-1:0]       flush;
    logic                    unused_ir;

`ifdef CONTROL_WATCHDOG_EN
    localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);
    logic [WdtW-1:0] wdt_q;
    logic            wdt_flush_q;

    assign wdt_flush = wdt_flush_q;
    // wdt_q counts completed MEM_WAIT cycles, so the limit is hit in the last allowed one.
    assign timeout   = (state_q == StMemWait) && !ctrl_io.memory_done_i &&
                       (wdt_q == WdtW'(WDT_CYCLES - 1));
    assign unused_ir = ^{ctrl_io.ir_i[31:25], ctrl_io.ir_i[14:0]};
`else
    assign wdt_flush = 1'b0;
    assign timeout   = 1'b0;
    assign unused_ir = ^{ctrl_io.ir_i[31:25], ctrl_io.ir_i[14:0], 32'(WDT_CYCLES)};
`endif

    // Hazard detection: memory wait (zero latency) and load-use on either source register.
    always_comb begin
        mem_stall = 1'b0;
        if (state_q == StMemWait) begin
            mem_stall = !ctrl_io.memory_done_i;
        end else if (!wdt_flush) begin
            mem_stall = ctrl_io.mem_req_i && !ctrl_io.memory_done_i;
        end
        load_use = ctrl_io.ex_load_i && (ctrl_io.ex_rd_i != 5'd0) &&
                   ((ctrl_io.ex_rd_i == ctrl_io.ir_i[19:15]) ||
                    (ctrl_io.ex_rd_i == ctrl_io.ir_i[24:20]));
    end

    // Stall/flush outputs by priority: memory wait > watchdog flush > flush counter > load-use.
    always_comb begin
        stall = '0;
        flush = '0;
        if (!rst) begin
            if (mem_stall) begin
                stall = '1;
            end else if (wdt_flush) begin
                flush = '1;
            end else if (fcnt_q != '0) begin
                flush = FlushMask;
            end else if ((state_q == StRun) && !ctrl_io.br_taken_i && load_use) begin
                stall = LuStallMask;
                flush = LuFlushMask;
            end
        end
    end

    // Control FSM with registered redirect outputs, pending-redirect latch and flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pend_q      <= 1'b0;
            tgt_q       <= '0;
            sel_q       <= '0;
            br_taken_q  <= 1'b0;
            next_pc_q   <= RESET_PC;
            pc_sel_q    <= '0;
            fcnt_q      <= '0;
`ifdef CONTROL_WATCHDOG_EN
            wdt_q       <= '0;
            wdt_flush_q <= 1'b0;
`endif
        end else begin
            br_taken_q <= 1'b0;
            if (fcnt_q != '0) begin
                fcnt_q <= fcnt_q - FcW'(1);
            end
`ifdef CONTROL_WATCHDOG_EN
            wdt_flush_q <= 1'b0;
`endif
            unique case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        state_q <= StMemWait;
`ifdef CONTROL_WATCHDOG_EN
                        wdt_q   <= '0;
`endif
                        // A branch resolved while memory stalls is kept for after the wait.
                        if (ctrl_io.br_taken_i) begin
                            pend_q <= 1'b1;
                            tgt_q  <= ctrl_io.next_pc_i;
                            sel_q  <= ctrl_io.pc_sel_i;
                        end
                    end else if (ctrl_io.br_taken_i) begin
                        state_q    <= StRedirect;
                        br_taken_q <= 1'b1;
                        next_pc_q  <= ctrl_io.next_pc_i;
                        pc_sel_q   <= ctrl_io.pc_sel_i;
                    end
                end
                StMemWait: begin
                    if (ctrl_io.memory_done_i) begin
                        pend_q <= 1'b0;
                        if (pend_q || ctrl_io.br_taken_i) begin
                            state_q    <= StRedirect;
                            br_taken_q <= 1'b1;
                            next_pc_q  <= pend_q ? tgt_q : ctrl_io.next_pc_i;
                            pc_sel_q   <= pend_q ? sel_q : ctrl_io.pc_sel_i;
                        end else begin
                            state_q <= StRun;
                        end
                    end else begin
                        // First captured redirect wins.
                        if (ctrl_io.br_taken_i && !pend_q) begin
                            pend_q <= 1'b1;
                            tgt_q  <= ctrl_io.next_pc_i;
                            sel_q  <= ctrl_io.pc_sel_i;
                        end
`ifdef CONTROL_WATCHDOG_EN
                        if (timeout) begin
                            state_q     <= StRun;
                            pend_q      <= 1'b0;
                            wdt_flush_q <= 1'b1;
                        end else begin
                            wdt_q <= wdt_q + WdtW'(1);
                        end
`endif
                    end
                end
                StRedirect: begin
                    state_q <= StRun;
                    fcnt_q  <= FcW'(FLUSH_STAGES);
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign ctrl_io.stall_o       = stall;
    assign ctrl_io.flush_o       = flush;
    assign ctrl_io.fetch_stall_o = stall[0];
    assign ctrl_io.pc_sel_o      = pc_sel_q;
    assign ctrl_io.br_taken_o    = br_taken_q;
    assign ctrl_io.next_pc_o     = next_pc_q;
    assign ctrl_io.timeout_o     = timeout;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: table of per-cycle vectors plus
// hand-written sequences for asynchronous reset and the optional watchdog.
module tb_pipeline_control;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipeline_control_if #(.XLEN(32), .SEL_PC_WIDTH(3), .NSTAGE(4)) ifc ();

    pipeline_control #(
        .XLEN        (32),
        .SEL_PC_WIDTH(3),
        .NSTAGE      (4),
        .FLUSH_STAGES(2),
        .RESET_PC    (32'h0000_0000),
        .WDT_CYCLES  (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mem_req;
        logic        done;
        logic        br;
        logic [31:0] npc;
        logic [2:0]  sel;
        logic [31:0] ir;
        logic        ld;
        logic [4:0]  rd;
        logic [3:0]  e_stall;
        logic [3:0]  e_flush;
        logic        e_br;
        logic [31:0] e_npc;
        logic [2:0]  e_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic mem_req, logic done, logic br, logic [31:0] npc,
                                logic [2:0] sel, logic [31:0] ir, logic ld, logic [4:0] rd,
                                logic [3:0] e_stall, logic [3:0] e_flush, logic e_br,
                                logic [31:0] e_npc, logic [2:0] e_sel);
        vec_t v;
        v.mem_req = mem_req; v.done = done; v.br = br; v.npc = npc; v.sel = sel;
        v.ir = ir; v.ld = ld; v.rd = rd;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_br = e_br;
        v.e_npc = e_npc; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mem_req, input logic done, input logic br,
                         input logic [31:0] npc, input logic [2:0] sel);
        ifc.mem_req_i     = mem_req;
        ifc.memory_done_i = done;
        ifc.br_taken_i    = br;
        ifc.next_pc_i     = npc;
        ifc.pc_sel_i      = sel;
        ifc.ir_i          = 32'h0;
        ifc.ex_load_i     = 1'b0;
        ifc.ex_rd_i       = 5'd0;
    endtask

    localparam logic [31:0] IrRs1x5 = 32'h0002_8033;  // rs1=x5, rs2=x0
    localparam logic [31:0] IrRs2x7 = 32'h0070_0033;  // rs1=x0, rs2=x7

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);

        // Reset held for 10 cycles.
        repeat (10) @(negedge clk);
        #1;
        chk("rst stall", 32'(ifc.stall_o), 32'h0);
        chk("rst flush", 32'(ifc.flush_o), 32'h0);
        chk("rst br_taken", 32'(ifc.br_taken_o), 32'h0);
        chk("rst next_pc", ifc.next_pc_o, 32'h0);
        chk("rst pc_sel", 32'(ifc.pc_sel_o), 32'h0);
        chk("rst timeout", 32'(ifc.timeout_o), 32'h0);
        rst = 1'b0;

        //            mreq done br  npc         sel  ir       ld    rd     stall  flush  bro   npc_o        sel_o
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h0,   3'd0)); // 0 idle
        vecs.push_back(mk(1, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'hF, 4'h0, 0, 32'h0,   3'd0)); // 1 wait
        vecs.push_back(mk(1, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'hF, 4'h0, 0, 32'h0,   3'd0)); // 2
        vecs.push_back(mk(1, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'hF, 4'h0, 0, 32'h0,   3'd0)); // 3
        vecs.push_back(mk(1, 1, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h0,   3'd0)); // 4 done
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h0,   3'd0)); // 5
        vecs.push_back(mk(0, 0, 1, 32'h100, 3'd1, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h0,   3'd0)); // 6 br
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 1, 32'h100, 3'd1)); // 7
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h100, 3'd1)); // 8
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h100, 3'd1)); // 9
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h100, 3'd1)); // 10
        vecs.push_back(mk(1, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'hF, 4'h0, 0, 32'h100, 3'd1)); // 11
        vecs.push_back(mk(1, 0, 1, 32'h200, 3'd2, 32'h0,   0, 5'd0, 4'hF, 4'h0, 0, 32'h100, 3'd1)); // 12
        vecs.push_back(mk(1, 0, 1, 32'h300, 3'd3, 32'h0,   0, 5'd0, 4'hF, 4'h0, 0, 32'h100, 3'd1)); // 13
        vecs.push_back(mk(1, 1, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h100, 3'd1)); // 14
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 1, 32'h200, 3'd2)); // 15
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h200, 3'd2)); // 16
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h200, 3'd2)); // 17
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h200, 3'd2)); // 18
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, IrRs1x5, 1, 5'd5, 4'h3, 4'h4, 0, 32'h200, 3'd2)); // 19 lu
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, IrRs1x5, 1, 5'd0, 4'h0, 4'h0, 0, 32'h200, 3'd2)); // 20 x0
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, IrRs2x7, 1, 5'd7, 4'h3, 4'h4, 0, 32'h200, 3'd2)); // 21 rs2
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, IrRs1x5, 0, 5'd5, 4'h0, 4'h0, 0, 32'h200, 3'd2)); // 22 no ld
        vecs.push_back(mk(0, 0, 1, 32'h400, 3'd4, IrRs1x5, 1, 5'd5, 4'h0, 4'h0, 0, 32'h200, 3'd2)); // 23
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, IrRs1x5, 1, 5'd5, 4'h0, 4'h0, 1, 32'h400, 3'd4)); // 24
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, IrRs1x5, 1, 5'd5, 4'h0, 4'h3, 0, 32'h400, 3'd4)); // 25
        vecs.push_back(mk(0, 0, 1, 32'h500, 3'd5, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h400, 3'd4)); // 26
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 1, 32'h500, 3'd5)); // 27
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h500, 3'd5)); // 28
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h500, 3'd5)); // 29
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h500, 3'd5)); // 30
        vecs.push_back(mk(1, 1, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h500, 3'd5)); // 31
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h500, 3'd5)); // 32
        vecs.push_back(mk(1, 0, 1, 32'h600, 3'd6, 32'h0,   0, 5'd0, 4'hF, 4'h0, 0, 32'h500, 3'd5)); // 33
        vecs.push_back(mk(1, 1, 1, 32'h600, 3'd6, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h500, 3'd5)); // 34
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 1, 32'h600, 3'd6)); // 35
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h600, 3'd6)); // 36
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h3, 0, 32'h600, 3'd6)); // 37
        vecs.push_back(mk(0, 0, 0, 32'h0,   3'd0, 32'h0,   0, 5'd0, 4'h0, 4'h0, 0, 32'h600, 3'd6)); // 38

        foreach (vecs[i]) begin
            @(negedge clk);
            ifc.mem_req_i     = vecs[i].mem_req;
            ifc.memory_done_i = vecs[i].done;
            ifc.br_taken_i    = vecs[i].br;
            ifc.next_pc_i     = vecs[i].npc;
            ifc.pc_sel_i      = vecs[i].sel;
            ifc.ir_i          = vecs[i].ir;
            ifc.ex_load_i     = vecs[i].ld;
            ifc.ex_rd_i       = vecs[i].rd;
            #1;
            chk($sformatf("row%0d stall", i), 32'(ifc.stall_o), 32'(vecs[i].e_stall));
            chk($sformatf("row%0d fetch_stall", i), 32'(ifc.fetch_stall_o),
                32'(vecs[i].e_stall[0]));
            chk($sformatf("row%0d flush", i), 32'(ifc.flush_o), 32'(vecs[i].e_flush));
            chk($sformatf("row%0d br_taken", i), 32'(ifc.br_taken_o), 32'(vecs[i].e_br));
            chk($sformatf("row%0d next_pc", i), ifc.next_pc_o, vecs[i].e_npc);
            chk($sformatf("row%0d pc_sel", i), 32'(ifc.pc_sel_o), 32'(vecs[i].e_sel));
            chk($sformatf("row%0d timeout", i), 32'(ifc.timeout_o), 32'h0);
        end

        // Asynchronous reset in MEM_WAIT with a pending redirect: pending must be lost.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        #1 chk("arst pre stall", 32'(ifc.stall_o), 32'hF);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h700, 3'd7);
        #1 chk("arst pend stall", 32'(ifc.stall_o), 32'hF);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        rst = 1'b1;
        #1;
        chk("arst stall", 32'(ifc.stall_o), 32'h0);
        chk("arst flush", 32'(ifc.flush_o), 32'h0);
        chk("arst next_pc", ifc.next_pc_o, 32'h0);
        chk("arst pc_sel", 32'(ifc.pc_sel_o), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("arst rel stall", 32'(ifc.stall_o), 32'hF);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 3'd0);
        #1 chk("arst done stall", 32'(ifc.stall_o), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        #1;
        chk("arst no redirect", 32'(ifc.br_taken_o), 32'h0);
        chk("arst pc kept", ifc.next_pc_o, 32'h0);

`ifdef CONTROL_WATCHDOG_EN
        // One RUN stall cycle, then 8 MEM_WAIT cycles; timeout on the 8th.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
            #1;
            chk($sformatf("wdt%0d stall", i), 32'(ifc.stall_o), 32'hF);
            chk($sformatf("wdt%0d timeout", i), 32'(ifc.timeout_o), (i == 8) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        #1;
        chk("wdt flush all", 32'(ifc.flush_o), 32'hF);
        chk("wdt stall drop", 32'(ifc.stall_o), 32'h0);
        chk("wdt timeout end", 32'(ifc.timeout_o), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        #1;
        chk("wdt flush end", 32'(ifc.flush_o), 32'h0);
        chk("wdt no redirect", 32'(ifc.br_taken_o), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
